ad936x_user_reg_bank: RTL and testbench
=======================================

// Module: ad936x_user_reg_bank
// PURPOSE
//   Control/status register bank on the user bus of axi_lite_to_user; sits between that
//   bridge and the ad936x LVDS datapath. Decodes single-word user writes and reads.
//   Drives datapath control, self-clearing command pulses and a stretched soft reset.
//   Collects sticky status flags and a sample counter.
// PARAMETERS
//   ADDR_W          8             user byte-address width; bits [1:0] ignored
//   DATA_W          32            user data width; fixed at 32
//   SOFT_RST_CYCLES 16            soft_rst_o high time in ACLK cycles, 1..255
//   VERSION         32'h0001_0000 value returned at VERSION register
// PORTS
//   ACLK            in   1       sole clock
//   ARESET          in   1       asynchronous, active-high reset
//   usr_wr_en       in   1       one-cycle write strobe from bridge
//   usr_wr_addr     in   ADDR_W  write byte address
//   usr_wr_data     in   32      write data
//   usr_rd_en       in   1       one-cycle read strobe from bridge
//   usr_rd_addr     in   ADDR_W  read byte address
//   usr_rd_data     out  32      read data, valid with usr_rd_valid
//   usr_rd_valid    out  1       one-cycle pulse, exactly 1 cycle after usr_rd_en
//   rx_en_o         out  1       CTRL[0]
//   tx_en_o         out  1       CTRL[1]
//   loopback_o      out  1       CTRL[2]
//   dly_tap_o       out  4       CTRL[7:4]
//   soft_rst_o      out  1       stretched soft reset to datapath
//   rx_sample_vld_i in   1       per-cycle sample strobe; counted
//   ovf_evt_i       in   1       overflow event pulse
//   udf_evt_i       in   1       underflow event pulse
// BEHAVIOUR
//   Map (byte addr): 0x00 CTRL rw | 0x04 SCRATCH rw | 0x08 CMD wo, reads 0
//     | 0x0C STATUS W1C | 0x10 RX_CNT ro | 0x14 VERSION ro | others: reads 0, writes dropped.
//   Reset: all outputs 0, CTRL=0, SCRATCH=0, STATUS=0, RX_CNT=0, stretch counter idle.
//   Writes: take effect on the ACLK edge that samples usr_wr_en. CTRL keeps only bits [7:4,2:0];
//     other bits read 0. Writes to ro registers are ignored.
//   Reads: usr_rd_data/valid registered; data reflects register state at the usr_rd_en edge.
//     This is the pre-write value if a write to the same address occurs in the same cycle.
//     usr_rd_data holds its last value when valid=0.
//   Simultaneous rd_en and wr_en: both are serviced; no stall; no back-pressure exists.
//   CMD[0] soft reset: FSM IDLE->STRETCH, soft_rst_o=1 on the next cycle.
//     soft_rst_o stays high for exactly SOFT_RST_CYCLES cycles, then IDLE.
//     A retrigger during STRETCH reloads the counter, extending the pulse.
//   CMD[1] cnt_clr: clears RX_CNT next cycle. Clear wins over a same-cycle increment (result 0).
//   RX_CNT: +1 per cycle with rx_sample_vld_i=1; saturates at 32'hFFFF_FFFF, no wrap.
//   STATUS[0]=ovf sticky, [1]=udf sticky; set by event pulse, cleared by writing 1 to the bit.
//     A same-cycle event and W1C leave the bit set (set wins).
//   soft_rst_o does not reset this bank; only ARESET does.
//   ARESET mid-stretch: soft_rst_o drops asynchronously to 0 and the FSM returns to IDLE.
// STRUCTURE
//   ad936x_reg_pkg: register offsets (REG_CTRL..REG_VERSION), CTRL/CMD/STATUS bit indices,
//     enum soft_rst_state_t {SR_IDLE, SR_STRETCH}.
//   Sub-module soft_rst_stretcher (trigger in, SOFT_RST_CYCLES param, pulse out).
//   Decode, register file and read mux stay in this module.
// TESTING
//   Reset then read 0x00..0x14 -> 0,0,0,0,0,32'h0001_0000; each usr_rd_valid exactly 1 cycle after rd_en.
//   Write CTRL=0xFFFF_FFFF -> rx_en_o=tx_en_o=loopback_o=1, dly_tap_o=0xF; readback 0x0000_00F7.
//   Write CMD=0x1 -> soft_rst_o high for exactly 16 cycles starting the next cycle.
//     Retrigger at cycle 10 -> 26 cycles total.
//   Hold rx_sample_vld_i 100 cycles -> RX_CNT=100.
//     CMD=0x2 coincident with vld=1 -> RX_CNT=0.
//     Force RX_CNT near max -> RX_CNT saturates at 0xFFFF_FFFF.
//   ovf_evt_i pulse -> STATUS=0x1. Write 0x1 to STATUS -> 0x0.
//     W1C coincident with a udf pulse -> STATUS[1]=1.
//   Same-cycle write SCRATCH=0xA5A5_A5A5 and read SCRATCH -> old value returned; a following read -> 0xA5A5_A5A5.
//   Assert ARESET mid-stretch -> soft_rst_o=0 immediately, all registers 0.

Source files
------------

// File: rtl/ad936x_reg_pkg.sv
// Register map, bit positions and soft-reset FSM states shared by the ad936x user register bank.
package ad936x_reg_pkg;

  localparam logic [31:0] REG_CTRL    = 32'h00;
  localparam logic [31:0] REG_SCRATCH = 32'h04;
  localparam logic [31:0] REG_CMD     = 32'h08;
  localparam logic [31:0] REG_STATUS  = 32'h0C;
  localparam logic [31:0] REG_RX_CNT  = 32'h10;
  localparam logic [31:0] REG_VERSION = 32'h14;

  localparam int CTRL_RX_EN    = 0;
  localparam int CTRL_TX_EN    = 1;
  localparam int CTRL_LOOPBACK = 2;
  localparam int CTRL_DLY_LSB  = 4;
  localparam int CTRL_DLY_MSB  = 7;
  localparam logic [31:0] CTRL_MASK = 32'h0000_00F7;

  localparam int CMD_SOFT_RST = 0;
  localparam int CMD_CNT_CLR  = 1;

  localparam int STATUS_OVF = 0;
  localparam int STATUS_UDF = 1;

  localparam logic [31:0] RX_CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic {
    SR_IDLE,
    SR_STRETCH
  } soft_rst_state_t;

endpackage

// File: rtl/soft_rst_stretcher.sv
// Stretches a one-cycle trigger into a CYCLES-long pulse starting the cycle after the trigger.
// A trigger while stretching reloads the count; pulse is decoded from state so reset clears it at once.
module soft_rst_stretcher
  import ad936x_reg_pkg::*;
#(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic pulse
);

  localparam logic [7:0] RELOAD = 8'(CYCLES - 1);

  soft_rst_state_t state, state_n;
  logic [7:0]      cnt, cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SR_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // cnt holds the number of high cycles still owed after the current one
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      SR_IDLE: begin
        if (trig) begin
          state_n = SR_STRETCH;
          cnt_n   = RELOAD;
        end
      end
      SR_STRETCH: begin
        if (trig) begin
          cnt_n = RELOAD;
        end else if (cnt == 8'd0) begin
          state_n = SR_IDLE;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: state_n = SR_IDLE;
    endcase
  end

  assign pulse = (state == SR_STRETCH);

endmodule

// File: rtl/ad936x_user_reg_bank.sv
// Control/status register bank on the bridge user bus: reads return one cycle after usr_rd_en,
// writes land on the sampling edge; no back-pressure, simultaneous read and write both serviced.
module ad936x_user_reg_bank
  import ad936x_reg_pkg::*;
#(
  parameter int          ADDR_W          = 8,
  parameter int          DATA_W          = 32,
  parameter int          SOFT_RST_CYCLES = 16,
  parameter logic [31:0] VERSION         = 32'h0001_0000
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              usr_wr_en,
  input  logic [ADDR_W-1:0] usr_wr_addr,
  input  logic [DATA_W-1:0] usr_wr_data,
  input  logic              usr_rd_en,
  input  logic [ADDR_W-1:0] usr_rd_addr,
  output logic [DATA_W-1:0] usr_rd_data,
  output logic              usr_rd_valid,
  output logic              rx_en_o,
  output logic              tx_en_o,
  output logic              loopback_o,
  output logic [3:0]        dly_tap_o,
  output logic              soft_rst_o,
  input  logic              rx_sample_vld_i,
  input  logic              ovf_evt_i,
  input  logic              udf_evt_i
);

  logic [31:0] wr_a, rd_a;
  logic        wr_ctrl, wr_scratch, wr_cmd, wr_status;
  logic        soft_rst_trig, cnt_clr;
  logic [31:0] ctrl_q, scratch_q, rx_cnt, rd_mux;
  logic [1:0]  status_q, status_set, status_clr;

  // Byte addresses with the sub-word bits dropped
  assign wr_a = 32'(usr_wr_addr) & ~32'h3;
  assign rd_a = 32'(usr_rd_addr) & ~32'h3;

  assign wr_ctrl    = usr_wr_en && (wr_a == REG_CTRL);
  assign wr_scratch = usr_wr_en && (wr_a == REG_SCRATCH);
  assign wr_cmd     = usr_wr_en && (wr_a == REG_CMD);
  assign wr_status  = usr_wr_en && (wr_a == REG_STATUS);

  assign soft_rst_trig = wr_cmd && usr_wr_data[CMD_SOFT_RST];
  assign cnt_clr       = wr_cmd && usr_wr_data[CMD_CNT_CLR];

  always_comb begin
    status_set             = '0;
    status_set[STATUS_OVF] = ovf_evt_i;
    status_set[STATUS_UDF] = udf_evt_i;
    status_clr             = wr_status ? usr_wr_data[1:0] : 2'b00;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ctrl_q    <= '0;
      scratch_q <= '0;
      status_q  <= '0;
      rx_cnt    <= '0;
    end else begin
      if (wr_ctrl)    ctrl_q    <= usr_wr_data & CTRL_MASK;
      if (wr_scratch) scratch_q <= usr_wr_data;
      // A new event outranks a same-cycle write-one-to-clear
      status_q <= (status_q & ~status_clr) | status_set;
      if (cnt_clr) begin
        rx_cnt <= '0;
      end else if (rx_sample_vld_i && (rx_cnt != RX_CNT_MAX)) begin
        rx_cnt <= rx_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_a)
      REG_CTRL:    rd_mux = ctrl_q;
      REG_SCRATCH: rd_mux = scratch_q;
      REG_STATUS:  rd_mux = {30'b0, status_q};
      REG_RX_CNT:  rd_mux = rx_cnt;
      REG_VERSION: rd_mux = VERSION;
      default:     rd_mux = '0;
    endcase
  end

  // Read data is sampled from pre-write state and held between reads
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      usr_rd_data  <= '0;
      usr_rd_valid <= 1'b0;
    end else begin
      usr_rd_valid <= usr_rd_en;
      if (usr_rd_en) usr_rd_data <= rd_mux;
    end
  end

  assign rx_en_o    = ctrl_q[CTRL_RX_EN];
  assign tx_en_o    = ctrl_q[CTRL_TX_EN];
  assign loopback_o = ctrl_q[CTRL_LOOPBACK];
  assign dly_tap_o  = ctrl_q[CTRL_DLY_MSB:CTRL_DLY_LSB];

  soft_rst_stretcher #(
    .CYCLES (SOFT_RST_CYCLES)
  ) u_soft_rst (
    .clk   (ACLK),
    .rst   (ARESET),
    .trig  (soft_rst_trig),
    .pulse (soft_rst_o)
  );

endmodule

// File: tb/tb_ad936x_user_reg_bank.sv
// Bench for ad936x_user_reg_bank: directed scenarios plus random traffic against a behavioural model.
module tb_ad936x_user_reg_bank;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        usr_wr_en = 1'b0;
  logic [7:0]  usr_wr_addr = '0;
  logic [31:0] usr_wr_data = '0;
  logic        usr_rd_en = 1'b0;
  logic [7:0]  usr_rd_addr = '0;
  logic [31:0] usr_rd_data;
  logic        usr_rd_valid;
  logic        rx_en_o, tx_en_o, loopback_o, soft_rst_o;
  logic [3:0]  dly_tap_o;
  logic        rx_sample_vld_i = 1'b0;
  logic        ovf_evt_i = 1'b0;
  logic        udf_evt_i = 1'b0;

  ad936x_user_reg_bank dut (
    .ACLK            (ACLK),
    .ARESET          (ARESET),
    .usr_wr_en       (usr_wr_en),
    .usr_wr_addr     (usr_wr_addr),
    .usr_wr_data     (usr_wr_data),
    .usr_rd_en       (usr_rd_en),
    .usr_rd_addr     (usr_rd_addr),
    .usr_rd_data     (usr_rd_data),
    .usr_rd_valid    (usr_rd_valid),
    .rx_en_o         (rx_en_o),
    .tx_en_o         (tx_en_o),
    .loopback_o      (loopback_o),
    .dly_tap_o       (dly_tap_o),
    .soft_rst_o      (soft_rst_o),
    .rx_sample_vld_i (rx_sample_vld_i),
    .ovf_evt_i       (ovf_evt_i),
    .udf_evt_i       (udf_evt_i)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model of the register bank
  logic [31:0] m_ctrl, m_scratch, m_status;
  longint      m_cnt;
  int          m_sr_left;
  logic [31:0] exp_rd_data;
  logic        exp_rd_vld;
  logic [31:0] rst_tbl [6];

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a & 8'hFC)
      8'h00:   return m_ctrl;
      8'h04:   return m_scratch;
      8'h0C:   return m_status;
      8'h10:   return 32'(m_cnt);
      8'h14:   return 32'h0001_0000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_scratch = '0; m_status = '0; m_cnt = 0; m_sr_left = 0;
    exp_rd_data = '0; exp_rd_vld = 1'b0;
  endtask

  task automatic check_outputs();
    chk("rd_valid", 32'(usr_rd_valid), 32'(exp_rd_vld));
    chk("rd_data", usr_rd_data, exp_rd_data);
    chk("ctrl_pins", 32'({dly_tap_o, 1'b0, loopback_o, tx_en_o, rx_en_o}), {24'b0, m_ctrl[7:0]});
    chk("soft_rst", 32'(soft_rst_o), 32'(m_sr_left > 0));
  endtask

  // Advance the model with the currently driven inputs, clock the DUT, then compare
  task automatic tick();
    bit trig = 1'b0;
    bit clr  = 1'b0;
    exp_rd_vld = usr_rd_en;
    if (usr_rd_en) exp_rd_data = m_read(usr_rd_addr);
    if (usr_wr_en) begin
      case (usr_wr_addr & 8'hFC)
        8'h00: m_ctrl = usr_wr_data & 32'h0000_00F7;
        8'h04: m_scratch = usr_wr_data;
        8'h08: begin trig = usr_wr_data[0]; clr = usr_wr_data[1]; end
        8'h0C: m_status = m_status & ~(usr_wr_data & 32'h3);
        default: ;
      endcase
    end
    m_status = m_status | {30'b0, udf_evt_i, ovf_evt_i};
    if (clr) m_cnt = 0;
    else if (rx_sample_vld_i && m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt = m_cnt + 1;
    if (trig) m_sr_left = 16;
    else if (m_sr_left > 0) m_sr_left = m_sr_left - 1;
    @(posedge ACLK);
    #1;
    check_outputs();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    usr_wr_en = 1'b1; usr_wr_addr = a; usr_wr_data = d;
    tick();
    usr_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    usr_rd_en = 1'b1; usr_rd_addr = a;
    tick();
    usr_rd_en = 1'b0;
    d = usr_rd_data;
  endtask

  task automatic check_reset_reads(input string tag);
    logic [31:0] d;
    for (int i = 0; i < 6; i++) begin
      rd(8'(i * 4), d);
      chk(tag, d, rst_tbl[i]);
    end
  endtask

  initial begin
    logic [31:0] d;
    int width;
    rst_tbl = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0001_0000};
    model_reset();

    // Reset state
    repeat (3) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    check_outputs();
    check_reset_reads("reset_read");

    // CTRL keeps only its defined bits
    wr(8'h00, 32'hFFFF_FFFF);
    chk("ctrl_pins_all", 32'({dly_tap_o, loopback_o, tx_en_o, rx_en_o}), 32'h7F);
    rd(8'h00, d);
    chk("ctrl_readback", d, 32'h0000_00F7);
    wr(8'h00, 32'h0);

    // Soft reset pulse width
    wr(8'h08, 32'h1);
    chk("sr_start", 32'(soft_rst_o), 32'h1);
    width = soft_rst_o ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (soft_rst_o) width++; else break;
    end
    chk("sr_width", 32'(width), 32'd16);

    // Retrigger ten cycles in
    wr(8'h08, 32'h1);
    width = soft_rst_o ? 1 : 0;
    repeat (9) begin
      tick();
      if (soft_rst_o) width++;
    end
    wr(8'h08, 32'h1);
    if (soft_rst_o) width++;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (soft_rst_o) width++; else break;
    end
    chk("sr_retrigger_width", 32'(width), 32'd26);

    // Sample counter
    wr(8'h08, 32'h2);
    rx_sample_vld_i = 1'b1;
    repeat (100) tick();
    rx_sample_vld_i = 1'b0;
    rd(8'h10, d);
    chk("rx_cnt_100", d, 32'd100);
    rx_sample_vld_i = 1'b1;
    wr(8'h08, 32'h2);
    rx_sample_vld_i = 1'b0;
    rd(8'h10, d);
    chk("rx_cnt_clr_wins", d, 32'd0);

    // Saturation from a preset near the top
    rx_sample_vld_i = 1'b1;
    force dut.rx_cnt = 32'hFFFF_FFFD;
    m_cnt = 64'h0000_0000_FFFF_FFFD;
    tick();
    release dut.rx_cnt;
    repeat (4) tick();
    rx_sample_vld_i = 1'b0;
    rd(8'h10, d);
    chk("rx_cnt_saturate", d, 32'hFFFF_FFFF);

    // Sticky status with write-one-to-clear
    wr(8'h0C, 32'h3);
    ovf_evt_i = 1'b1;
    tick();
    ovf_evt_i = 1'b0;
    rd(8'h0C, d);
    chk("status_ovf", d, 32'h1);
    wr(8'h0C, 32'h1);
    rd(8'h0C, d);
    chk("status_w1c", d, 32'h0);
    udf_evt_i = 1'b1;
    wr(8'h0C, 32'h2);
    udf_evt_i = 1'b0;
    rd(8'h0C, d);
    chk("status_set_wins", d, 32'h2);

    // Same-cycle read and write of SCRATCH
    wr(8'h04, 32'h1234_5678);
    usr_rd_en = 1'b1; usr_rd_addr = 8'h04;
    wr(8'h04, 32'hA5A5_A5A5);
    usr_rd_en = 1'b0;
    chk("scratch_old", usr_rd_data, 32'h1234_5678);
    rd(8'h04, d);
    chk("scratch_new", d, 32'hA5A5_A5A5);
    rd(8'h1C, d);
    chk("unmapped_read", d, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      usr_wr_en       = ($urandom_range(0, 3) == 0);
      usr_wr_addr     = 8'(($urandom_range(0, 7) * 4) + $urandom_range(0, 3));
      usr_wr_data     = $urandom;
      usr_rd_en       = ($urandom_range(0, 2) == 0);
      usr_rd_addr     = 8'(($urandom_range(0, 7) * 4) + $urandom_range(0, 3));
      rx_sample_vld_i = 1'($urandom_range(0, 1));
      ovf_evt_i       = ($urandom_range(0, 15) == 0);
      udf_evt_i       = ($urandom_range(0, 15) == 0);
      tick();
    end
    usr_wr_en = 1'b0; usr_rd_en = 1'b0;
    rx_sample_vld_i = 1'b0; ovf_evt_i = 1'b0; udf_evt_i = 1'b0;
    repeat (20) tick();

    // Asynchronous reset in the middle of a stretch
    wr(8'h00, 32'h35);
    wr(8'h04, 32'hDEAD_BEEF);
    wr(8'h08, 32'h1);
    repeat (5) tick();
    chk("sr_before_arst", 32'(soft_rst_o), 32'h1);
    #2;
    ARESET = 1'b1;
    #1;
    chk("arst_soft_rst", 32'(soft_rst_o), 32'h0);
    chk("arst_ctrl_pins", 32'({dly_tap_o, loopback_o, tx_en_o, rx_en_o}), 32'h0);
    model_reset();
    @(posedge ACLK);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    check_outputs();
    check_reset_reads("arst_read");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
